calc_arbiter: RTL
=================

CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 SHALL have parameter W, default 16, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1 each  requester n presents a command.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1 each  command accepted this cycle when valid&ready.
REQ-006 SHALL have ports req0_op/req1_op  input  3 each  CombCalc opcode (000 A+B, 001 A-B, 01x |B|, 100 B+A, 101 B-A, 11x |A|).
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  W each  operands.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port res_id  output  1  requester index that owns the result.
REQ-011 SHALL have port res_r  output  W  result value.
REQ-012 SHALL have port res_ovf  output  1  overflow flag of the result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port ovf_count  output  8  saturating count of delivered results with res_ovf=1.

Function
REQ-015 SHALL share one internal CombCalc instance of width W between both requesters, fed only from registered op/A/B.
REQ-016 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-017 IDLE: if either valid, SHALL grant one requester, assert its ready combinationally (the other ready low), latch op/A/B/id, go to EXEC; if neither valid, stay IDLE.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; with one valid, grant it regardless of pointer.
REQ-019 Last-served pointer SHALL update at grant time.
REQ-020 EXEC: SHALL register CombCalc R and ovf into res_r/res_ovf, set res_valid=1, go to HOLD (exactly one cycle).
REQ-021 HOLD: res_valid, res_id, res_r, res_ovf SHALL remain stable until res_valid&res_ready; on that edge res_valid=0, go to IDLE.
REQ-022 Both req readys SHALL be low in EXEC and HOLD; no command is accepted while a result is pending.
REQ-023 Latency: res_valid SHALL rise 2 edges after the accepting edge; minimum command interval 3 cycles with res_ready held high.
REQ-024 ovf_count SHALL increment on each result handshake with res_ovf=1 and saturate at 255 (no wrap).
REQ-025 Requester valid dropping without handshake SHALL have no effect; commands are latched only on the accepting edge.
REQ-026 Arithmetic SHALL be two's complement W-bit, identical to CombCalc, including ovf=1 for |most-negative| (result passes through unchanged).

Reset
REQ-027 With reset high at a rising edge, next state SHALL be IDLE regardless of current state, including mid-EXEC or mid-HOLD.
REQ-028 Reset values: res_valid=0, res_id=0, res_r=0, res_ovf=0, ovf_count=0, busy=0, latched op/A/B=0.
REQ-029 Reset SHALL set the pointer to "requester 1 served last" so requester 0 wins the first contention.
REQ-030 An in-flight command interrupted by reset SHALL be discarded, producing no result.

Verification
REQ-031 req0 op=000 A=3 B=5 accepted at edge N -> res_valid at edge N+2, res_r=8, res_id=0, res_ovf=0.
REQ-032 Both valid after reset (req0 A+B 1,1; req1 A-B 9,4), res_ready=1 -> req0 served first (res_r=2, id 0), then req1 (res_r=5, id 1); with both held valid, grants alternate 0,1,0,1.
REQ-033 req1 op=001 A=0x8000 B=0x0001 -> res_r=0x7FFF, res_ovf=1, ovf_count 0->1 on handshake.
REQ-034 op=110 A=0x8000 -> res_ovf=1, res_r=0x8000; op=010 B=0xFFFB -> res_r=0x0005, res_ovf=0.
REQ-035 res_ready low 5 cycles in HOLD -> res_r/res_id/res_ovf stable, both readys low, busy=1; one cycle after res_ready rises, res_valid=0 and a new grant may occur.
REQ-036 Reset asserted in EXEC -> next cycle all outputs at reset values, no result for that command; 256 overflowing results -> ovf_count=255.

Source files
------------

// File: rtl/calc_arbiter.sv
// Two-requester round-robin front end sharing one registered-operand calculator.
// Commands are accepted in IDLE, computed in EXEC and held in HOLD until the consumer takes them.
module calc_arbiter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [W-1:0] res_r,
    output logic         res_ovf,
    output logic         busy,
    output logic [7:0]   ovf_count
);

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_last;
    logic [2:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_id;
    logic         r_res_valid;
    logic         r_res_id;
    logic [W-1:0] r_res_r;
    logic         r_res_ovf;
    logic         r_busy;
    logic [7:0]   r_ovf_count;

    logic         w_grant_any;
    logic         w_grant_id;
    logic         w_res_fire;
    logic [W-1:0] w_x;
    logic [W-1:0] w_y;
    logic [W-1:0] w_abs_in;
    logic [W-1:0] w_calc_r;
    logic         w_calc_ovf;

    // Next-state, round-robin grant and combinational readys
    always_comb begin
        w_next      = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        w_grant_any = 1'b0;
        w_grant_id  = 1'b0;
        w_res_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_grant_any = 1'b1;
                    // r_last=1 means requester 1 was served last, so 0 wins contention
                    w_grant_id  = (req0_valid && req1_valid) ? ~r_last : req1_valid;
                    req0_ready  = ~w_grant_id;
                    req1_ready  = w_grant_id;
                    w_next      = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_res_fire = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Shared calculator: op[2] swaps operands, op[1] selects abs, op[0] selects subtract
    always_comb begin
        w_x        = r_op[2] ? r_b : r_a;
        w_y        = r_op[2] ? r_a : r_b;
        w_abs_in   = r_op[2] ? r_a : r_b;
        w_calc_r   = '0;
        w_calc_ovf = 1'b0;
        if (r_op[1]) begin
            if (w_abs_in[W-1]) begin
                w_calc_r   = W'(0) - w_abs_in;
                w_calc_ovf = (w_abs_in == MIN_NEG);
            end else begin
                w_calc_r   = w_abs_in;
            end
        end else if (r_op[0]) begin
            w_calc_r   = w_x - w_y;
            w_calc_ovf = (w_x[W-1] != w_y[W-1]) && (w_calc_r[W-1] != w_x[W-1]);
        end else begin
            w_calc_r   = w_x + w_y;
            w_calc_ovf = (w_x[W-1] == w_y[W-1]) && (w_calc_r[W-1] != w_x[W-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_r     <= '0;
            r_res_ovf   <= 1'b0;
            r_busy      <= 1'b0;
            r_ovf_count <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            if (w_grant_any) begin
                r_op   <= w_grant_id ? req1_op : req0_op;
                r_a    <= w_grant_id ? req1_a  : req0_a;
                r_b    <= w_grant_id ? req1_b  : req0_b;
                r_id   <= w_grant_id;
                r_last <= w_grant_id;
            end
            if (r_state == S_EXEC) begin
                r_res_r     <= w_calc_r;
                r_res_ovf   <= w_calc_ovf;
                r_res_id    <= r_id;
                r_res_valid <= 1'b1;
            end
            if (w_res_fire) begin
                r_res_valid <= 1'b0;
                if (r_res_ovf && (r_ovf_count != 8'hFF)) begin
                    r_ovf_count <= r_ovf_count + 8'd1;
                end
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_r     = r_res_r;
    assign res_ovf   = r_res_ovf;
    assign busy      = r_busy;
    assign ovf_count = r_ovf_count;

endmodule
